alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational alu between two requesters (req0 = main datapath,
//  req1 = auxiliary unit, e.g. address/DMA helper). Round-robin grant, valid/ready
//  handshake per requester, one registered response slot with backpressure.
//  Drives alu operand/op ports and captures C/zero on the issue edge.
// PARAMETERS
//  TAG_W   4   width of the requester-supplied tag carried to the response
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  req_valid    in   2      [i]: requester i presents an op
//  req_ready    out  2      [i]: op from requester i accepted this cycle
//  req0_op      in   5      ALUOp code (`ALUOp_* from ctrl_encode_def.v)
//  req0_a/req0_b in  32     operands A (rs), B (rt/imm)
//  req0_sa      in   5      shift amount
//  req0_tag     in   TAG_W  opaque tag
//  req1_op/a/b/sa/tag  in   same as req0_*
//  alu_op       out  5      to alu ALUOp
//  alu_a/alu_b  out  32     to alu A/B
//  alu_sa       out  5      to alu sa
//  alu_c        in   32     from alu C
//  alu_zero     in   1      from alu zero
//  rsp_valid    out  1      response slot full
//  rsp_ready    in   1      consumer takes response
//  rsp_id       out  1      requester index of response
//  rsp_tag      out  TAG_W  tag of response
//  rsp_c        out  32     captured alu_c
//  rsp_zero     out  1      captured alu_zero (meaningful only for EQL/BNE ops)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_c=0, rsp_zero=0, last_grant=1
//    (so req0 wins first contention); state=EMPTY. Reset mid-transaction drops slot.
//  - FSM: EMPTY (slot free), FULL (slot holds unconsumed response).
//    can_accept = (state==EMPTY) | (state==FULL & rsp_ready).
//  - Grant (comb): only req0 valid -> 0; only req1 -> 1; both -> ~last_grant; none -> none.
//  - req_ready[g] = can_accept & req_valid[g] for granted g only; other bit 0.
//    Requesters must not make valid depend on ready; once valid, hold payload until ready.
//  - alu_* ports mux the granted requester's payload; when no grant, mux req0 payload
//    (don't care, alu output ignored).
//  - Issue (fire = |req_ready): on that edge rsp_c<=alu_c, rsp_zero<=alu_zero,
//    rsp_id<=g, rsp_tag<=tag, last_grant<=g, state->FULL. Latency: accept edge ->
//    rsp_valid high next cycle (1 cycle).
//  - FULL & rsp_ready & fire: old response retired and new one loaded same edge; stays FULL
//    (sustained throughput 1 op/cycle).
//  - FULL & rsp_ready & ~fire -> EMPTY, rsp_valid=0. FULL & ~rsp_ready: all rsp_* hold,
//    req_ready=0.
//  - EMPTY & ~fire: stays EMPTY; rsp_* data holds last value.
//  - last_grant updates only on fire; single requester streaming never blocked.
//  - alu zero is state-holding for non-branch ops; arbiter captures as-is, no fixup.
//  - Arithmetic entirely inside alu; arbiter performs no width changes.
// TESTING
//  1 Reset then req0 ADD a=5 b=7 tag=3, rsp_ready=1 -> req_ready=2'b01 cycle0;
//    next cycle rsp_valid=1 rsp_c=12 rsp_id=0 rsp_tag=3.
//  2 Both valid held 4 cycles (req0 SUB 9-4, req1 OR F0|0F), rsp_ready=1 -> grants
//    0,1,0,1; responses c=5,FF,5,FF alternating ids.
//  3 req1 SLL b=1 sa=4 with rsp_ready=0 for 3 cycles -> rsp_valid=1 c=0x10 held stable,
//    req_ready=0 while full; rsp_ready=1 -> slot drains, next op accepted same edge.
//  4 req0 EQL a=b=0x1234 then BNE a=1 b=2 -> rsp_zero=1 then rsp_zero=1; EQL a=1 b=2 -> 0.
//  5 rst pulsed while FULL with req1 pending -> rsp_valid=0 next cycle; first grant
//    after reset with both valid goes to req0.
//  6 Random valid/rsp_ready traffic 10k cycles vs. scoreboard -> in-order per requester,
//    no lost/duplicated tags, no requester waits >1 grant while other streams.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational alu.
// One registered response slot with valid/ready backpressure.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [4:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_sa,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [4:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_sa,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_sa,
    input  logic [31:0]      alu_c,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_c,
    output logic             rsp_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             gnt;
    logic             gnt_any;
    logic             can_accept;
    logic             fire;
    logic [TAG_W-1:0] gnt_tag;

    // Round-robin pick: contention goes to whoever did not win last time
    always_comb begin
        gnt_any = |req_valid;
        gnt     = 1'b0;
        unique case (req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

    // Accept only when the slot is free or being drained this cycle
    always_comb begin
        can_accept = (state == EMPTY) || rsp_ready;
        req_ready  = 2'b00;
        if (can_accept && gnt_any) begin
            req_ready[gnt] = 1'b1;
        end
        fire = |req_ready;
    end

    // Steer the granted payload to the alu; idle cycles show req0
    always_comb begin
        alu_op  = req0_op;
        alu_a   = req0_a;
        alu_b   = req0_b;
        alu_sa  = req0_sa;
        gnt_tag = req0_tag;
        if (gnt_any && gnt) begin
            alu_op  = req1_op;
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sa  = req1_sa;
            gnt_tag = req1_tag;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Slot fills on issue, empties when drained with nothing new arriving
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (fire) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !fire) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Fairness pointer moves only when an op is actually issued
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (fire) begin
            last_grant <= gnt;
        end
    end

    // Capture alu result and its owner on the issue edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_c    <= '0;
            rsp_zero <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_tag  <= '0;
        end else if (fire) begin
            rsp_c    <= alu_c;
            rsp_zero <= alu_zero;
            rsp_id   <= gnt;
            rsp_tag  <= gnt_tag;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule
